// File: rtl/hex_msg_sequencer_if.sv
// Bus bundle for the HEX message sequencer: raw keys and message words in,
// segment drive, message index and mode flag out.
interface hex_msg_sequencer_if #(
  parameter int N_MSG    = 2,
  parameter int N_DIGITS = 6
);
  localparam int MSG_W = (N_MSG > 1) ? $clog2(N_MSG) : 1;

  logic                        key_next_n;
  logic                        key_mode_n;
  logic [N_MSG*N_DIGITS*4-1:0] msg_bus;
  logic [N_DIGITS*8-1:0]       hex_segs;
  logic [MSG_W-1:0]            msg_idx;
  logic                        auto_mode;

  modport master (
    output key_next_n, key_mode_n, msg_bus,
    input  hex_segs, msg_idx, auto_mode
  );

  modport slave (
    input  key_next_n, key_mode_n, msg_bus,
    output hex_segs, msg_idx, auto_mode
  );
endinterface

// File: rtl/hex_msg_sequencer.sv
// Seven-segment message sequencer: debounced keys, auto dwell stepping, registered HEX decode.
// Optional macro HEX_LZB_EN enables leading-zero blanking of the displayed message.
module hex_msg_sequencer #(
  parameter int N_MSG           = 2,
  parameter int N_DIGITS        = 6,
  parameter int DWELL_CYCLES    = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic              clk,
  input logic              rst,
  hex_msg_sequencer_if.slave bus
);
  localparam int MSG_W = (N_MSG > 1) ? $clog2(N_MSG) : 1;
  localparam int DW_W  = $clog2(DWELL_CYCLES);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [MSG_W-1:0] MSG_LAST   = MSG_W'(N_MSG - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  // Active-low {dp,g..a}; dp left dark here and set by the caller.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 8'hC0;  4'h1: seg_decode = 8'hF9;
      4'h2: seg_decode = 8'hA4;  4'h3: seg_decode = 8'hB0;
      4'h4: seg_decode = 8'h99;  4'h5: seg_decode = 8'h92;
      4'h6: seg_decode = 8'h82;  4'h7: seg_decode = 8'hF8;
      4'h8: seg_decode = 8'h80;  4'h9: seg_decode = 8'h90;
      4'hA: seg_decode = 8'h88;  4'hB: seg_decode = 8'h83;
      4'hC: seg_decode = 8'hC6;  4'hD: seg_decode = 8'hA1;
      4'hE: seg_decode = 8'h86;  default: seg_decode = 8'h8E;
    endcase
  endfunction

  logic [1:0]      raw_n, sync1, sync2, deb, deb_d1, press;
  logic [DB_W-1:0] db_cnt [2];
  logic            next_p, mode_p;

  assign raw_n  = {bus.key_mode_n, bus.key_next_n};
  assign press  = deb_d1 & ~deb;
  assign next_p = press[0];
  assign mode_p = press[1];

  // Key conditioning: two-flop sync, then a level must persist DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '1;
      sync2  <= '1;
      deb    <= '1;
      deb_d1 <= '1;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      sync1  <= raw_n;
      sync2  <= sync1;
      deb_d1 <= deb;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] != deb[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            deb[k]    <= sync2[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + DB_W'(1);
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  logic [MSG_W-1:0] idx;
  logic             auto_q;
  logic [DW_W-1:0]  dwell_cnt;
  logic             dwell_done, advance;

  assign dwell_done = auto_q && (dwell_cnt == DWELL_LAST);
  assign advance    = next_p || dwell_done;

  // Control stage: mode toggle, dwell timer, message index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      auto_q    <= 1'b1;
      dwell_cnt <= '0;
    end else begin
      if (mode_p) auto_q <= ~auto_q;
      if (mode_p && !auto_q) begin
        dwell_cnt <= '0;
      end else if (auto_q) begin
        dwell_cnt <= advance ? '0 : dwell_cnt + DW_W'(1);
      end
      if (advance) idx <= (idx == MSG_LAST) ? '0 : idx + MSG_W'(1);
    end
  end

  logic [N_DIGITS*4-1:0] msg_sel;
  logic [N_DIGITS*8-1:0] seg_nxt, seg_p1;

  always_comb begin
`ifdef HEX_LZB_EN
    logic lead;
    lead = 1'b1;
`endif
    msg_sel = '0;
    seg_nxt = '1;
    for (int m = 0; m < N_MSG; m++) begin
      if (idx == MSG_W'(m)) msg_sel = bus.msg_bus[m*N_DIGITS*4 +: N_DIGITS*4];
    end
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
`ifdef HEX_LZB_EN
      // Blank zeros until the first nonzero digit; digit 0 always shows.
      if (lead && (d != 0) && (msg_sel[d*4 +: 4] == 4'h0)) begin
        seg_nxt[d*8 +: 8] = 8'hFF;
      end else begin
        lead              = 1'b0;
        seg_nxt[d*8 +: 8] = seg_decode(msg_sel[d*4 +: 4]);
      end
`else
      seg_nxt[d*8 +: 8] = seg_decode(msg_sel[d*4 +: 4]);
`endif
    end
    seg_nxt[7] = ~auto_q;
  end

  // Display stage: registered segment drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seg_p1 <= '1;
    else     seg_p1 <= seg_nxt;
  end

  assign bus.hex_segs  = seg_p1;
  assign bus.msg_idx   = idx;
  assign bus.auto_mode = auto_q;
endmodule

// File: tb/tb_hex_msg_sequencer.sv
// Directed bench for hex_msg_sequencer: reset, dwell, debounce, mode, coincident events, blanking.
module tb_hex_msg_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  hex_msg_sequencer_if #(.N_MSG(2), .N_DIGITS(6)) bus_if ();

  hex_msg_sequencer #(
    .N_MSG(2), .N_DIGITS(6), .DWELL_CYCLES(10), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

`ifdef HEX_LZB_EN
  localparam logic [47:0] MSG0_A = 48'hFF82F9B0C040;
  localparam logic [47:0] A05_A  = 48'hFFFFFF88C012;
  localparam logic [47:0] Z_A    = 48'hFFFFFFFFFF40;
`else
  localparam logic [47:0] MSG0_A = 48'hC082F9B0C040;
  localparam logic [47:0] A05_A  = 48'hC0C0C088C012;
  localparam logic [47:0] Z_A    = 48'hC0C0C0C0C040;
`endif
  localparam logic [47:0] MSG1_A = 48'hF9A4F9809010;
  localparam logic [47:0] MSG1_M = 48'hF9A4F9809090;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus_if.key_next_n = 1'b1;
    bus_if.key_mode_n = 1'b1;
    bus_if.msg_bus    = {24'h121899, 24'h061300};

    tick(3);
    chk("rst_hex",  64'(bus_if.hex_segs),  64'hFFFFFFFFFFFF);
    chk("rst_idx",  64'(bus_if.msg_idx),   64'd0);
    chk("rst_auto", 64'(bus_if.auto_mode), 64'd1);
    rst = 1'b0;

    tick(1);
    chk("hex_msg0", 64'(bus_if.hex_segs),  64'(MSG0_A));
    chk("idx_e1",   64'(bus_if.msg_idx),   64'd0);
    chk("auto_e1",  64'(bus_if.auto_mode), 64'd1);
    tick(8);
    chk("dwell_e9",  64'(bus_if.msg_idx), 64'd0);
    tick(1);
    chk("dwell_e10", 64'(bus_if.msg_idx), 64'd1);
    chk("hex_lag",   64'(bus_if.hex_segs), 64'(MSG0_A));
    tick(1);
    chk("hex_msg1",  64'(bus_if.hex_segs), 64'(MSG1_A));
    tick(8);
    chk("dwell_e19", 64'(bus_if.msg_idx), 64'd1);
    tick(1);
    chk("dwell_wrap", 64'(bus_if.msg_idx), 64'd0);

    // 3-cycle glitch on next key
    bus_if.key_next_n = 1'b0;
    tick(3);
    bus_if.key_next_n = 1'b1;
    tick(6);
    chk("glitch", 64'(bus_if.msg_idx), 64'd0);
    tick(1);
    chk("dwell_e30", 64'(bus_if.msg_idx), 64'd1);

    // held press: advance on 7th edge, dwell restarts
    bus_if.key_next_n = 1'b0;
    tick(6);
    chk("next_e6", 64'(bus_if.msg_idx), 64'd1);
    tick(1);
    chk("next_e7", 64'(bus_if.msg_idx), 64'd0);
    bus_if.key_next_n = 1'b1;
    tick(9);
    chk("restart_e9",  64'(bus_if.msg_idx), 64'd0);
    tick(1);
    chk("restart_e10", 64'(bus_if.msg_idx), 64'd1);

    // mode to manual
    bus_if.key_mode_n = 1'b0;
    tick(6);
    chk("mode_e6", 64'(bus_if.auto_mode), 64'd1);
    tick(1);
    chk("mode_e7", 64'(bus_if.auto_mode), 64'd0);
    bus_if.key_mode_n = 1'b1;
    tick(1);
    chk("hex_manual", 64'(bus_if.hex_segs), 64'(MSG1_M));
    tick(50);
    chk("frozen_idx",  64'(bus_if.msg_idx),   64'd1);
    chk("frozen_auto", 64'(bus_if.auto_mode), 64'd0);

    // manual presses 1 -> 0 -> 1
    bus_if.key_next_n = 1'b0;
    tick(6);
    chk("man1_e6", 64'(bus_if.msg_idx), 64'd1);
    tick(1);
    chk("man1_e7", 64'(bus_if.msg_idx), 64'd0);
    bus_if.key_next_n = 1'b1;
    tick(10);
    bus_if.key_next_n = 1'b0;
    tick(6);
    chk("man2_e6", 64'(bus_if.msg_idx), 64'd0);
    tick(1);
    chk("man2_e7", 64'(bus_if.msg_idx), 64'd1);
    bus_if.key_next_n = 1'b1;
    tick(1);
    chk("hex_man2", 64'(bus_if.hex_segs), 64'(MSG1_M));
    tick(9);

    // back to auto, dwell from 0
    bus_if.key_mode_n = 1'b0;
    tick(7);
    chk("auto_back", 64'(bus_if.auto_mode), 64'd1);
    bus_if.key_mode_n = 1'b1;
    tick(9);
    chk("resume_e9",  64'(bus_if.msg_idx), 64'd1);
    tick(1);
    chk("resume_e10", 64'(bus_if.msg_idx), 64'd0);

    // next pulse coincident with dwell expiry
    tick(3);
    bus_if.key_next_n = 1'b0;
    tick(6);
    chk("coinc_pre",  64'(bus_if.msg_idx), 64'd0);
    tick(1);
    chk("coinc_once", 64'(bus_if.msg_idx), 64'd1);
    bus_if.key_next_n = 1'b1;
    tick(9);
    chk("coinc_clr9",  64'(bus_if.msg_idx), 64'd1);
    tick(1);
    chk("coinc_clr10", 64'(bus_if.msg_idx), 64'd0);

    // mode and next together
    bus_if.key_next_n = 1'b0;
    bus_if.key_mode_n = 1'b0;
    tick(6);
    chk("both_pre_idx",  64'(bus_if.msg_idx),   64'd0);
    chk("both_pre_auto", 64'(bus_if.auto_mode), 64'd1);
    tick(1);
    chk("both_idx",  64'(bus_if.msg_idx),   64'd1);
    chk("both_auto", 64'(bus_if.auto_mode), 64'd0);
    bus_if.key_next_n = 1'b1;
    bus_if.key_mode_n = 1'b1;
    tick(10);

    // reset mid-debounce
    bus_if.key_next_n = 1'b0;
    tick(3);
    rst = 1'b1;
    #1;
    chk("mid_rst_hex",  64'(bus_if.hex_segs),  64'hFFFFFFFFFFFF);
    chk("mid_rst_idx",  64'(bus_if.msg_idx),   64'd0);
    chk("mid_rst_auto", 64'(bus_if.auto_mode), 64'd1);
    bus_if.key_next_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(9);
    chk("post_rst_e9",  64'(bus_if.msg_idx), 64'd0);
    tick(1);
    chk("post_rst_e10", 64'(bus_if.msg_idx), 64'd1);

    // live msg_bus change and zero handling
    bus_if.msg_bus = {24'h000000, 24'h000A05};
    tick(1);
    chk("hex_zero", 64'(bus_if.hex_segs), 64'(Z_A));
    tick(9);
    chk("zero_idx", 64'(bus_if.msg_idx), 64'd0);
    tick(1);
    chk("hex_a05", 64'(bus_if.hex_segs), 64'(A05_A));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
